// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants, types and helpers for the tick generator.
//   MAX_NCH   - largest supported channel count
//   DEF_CW    - default counter/period width
//   tick_mode_t - channel mode (periodic / one-shot)
//   ch_idx_w  - width of a channel index for a given channel count
package tick_gen_pkg;

  localparam int MAX_NCH = 16;
  localparam int DEF_CW  = 27;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } tick_mode_t;

  // A single channel still needs a 1-bit select port.
  function automatic int ch_idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// tick_channel: one channel of the tick generator.
// Optional feature macro: TICK_GEN_SQW_EN (adds the sqw divided square wave).
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   en             global run; low freezes the counter
//   wr_en          configuration write aimed at this channel
//   wr_period      new period P (0 disables the channel)
//   wr_mode        new mode (periodic / one-shot)
//   tick           registered one-cycle strobe every P enabled cycles
//   busy           channel armed (P != 0 and one-shot not yet expired)
//   sqw            toggles on every tick (only with TICK_GEN_SQW_EN)
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_period,
  input  tick_mode_t    wr_mode,
`ifdef TICK_GEN_SQW_EN
  output logic          sqw,
`endif
  output logic          tick,
  output logic          busy
);

  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] cnt_q, cnt_d;
  tick_mode_t    mode_q, mode_d;
  logic          busy_q, busy_d;
  logic          tick_q, tick_d;
`ifdef TICK_GEN_SQW_EN
  logic          sqw_q, sqw_d;
`endif

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    busy_d   = busy_q;
    tick_d   = 1'b0;      // strobe: never held, never queued
`ifdef TICK_GEN_SQW_EN
    sqw_d    = sqw_q;
`endif
    if (wr_en) begin
      // A write restarts the channel and wins over a coincident terminal count.
      period_d = wr_period;
      mode_d   = wr_mode;
      cnt_d    = '0;
      busy_d   = (wr_period != '0);
`ifdef TICK_GEN_SQW_EN
      sqw_d    = 1'b0;
`endif
    end else if (en && busy_q) begin
      // busy_q guarantees period_q != 0, so period_q-1 never wraps.
      if (cnt_q == period_q - CW'(1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (mode_q == MODE_ONESHOT) begin
          busy_d = 1'b0;
        end
`ifdef TICK_GEN_SQW_EN
        sqw_d  = ~sqw_q;
`endif
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_PERIODIC;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
`ifdef TICK_GEN_SQW_EN
      sqw_q    <= 1'b0;
`endif
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
`ifdef TICK_GEN_SQW_EN
      sqw_q    <= sqw_d;
`endif
    end
  end

  assign tick = tick_q;
  assign busy = busy_q;
`ifdef TICK_GEN_SQW_EN
  assign sqw  = sqw_q;
`endif

endmodule

// File: rtl/tick_generator.sv
// tick_generator: NCH independent run-time programmable tick channels.
// Optional feature macro: TICK_GEN_SQW_EN (adds the sqw output port).
// All outputs are data-path enables, not clocks.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   en             global run; low freezes every channel
//   cfg_we         configuration write strobe
//   cfg_ch         target channel; values >= NCH are ignored
//   cfg_period     period P in cycles; 0 disables the channel
//   cfg_oneshot    1 = one-shot, 0 = periodic
//   tick[NCH]      per-channel one-cycle registered strobe
//   busy[NCH]      per-channel armed flag
//   sqw[NCH]       per-channel square wave of period 2P (TICK_GEN_SQW_EN only)
module tick_generator
  import tick_gen_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = DEF_CW,
  localparam int CHW = ch_idx_w(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic           cfg_oneshot,
  output logic [NCH-1:0] tick,
`ifdef TICK_GEN_SQW_EN
  output logic [NCH-1:0] sqw,
`endif
  output logic [NCH-1:0] busy
);

  logic [NCH-1:0] wr_sel;
  tick_mode_t     wr_mode;

  assign wr_mode = cfg_oneshot ? MODE_ONESHOT : MODE_PERIODIC;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      // Exact-match decode: indices NCH..2**CHW-1 select no channel.
      assign wr_sel[gi] = cfg_we && (cfg_ch == CHW'(gi));

      tick_channel #(
        .CW(CW)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wr_en    (wr_sel[gi]),
        .wr_period(cfg_period),
        .wr_mode  (wr_mode),
`ifdef TICK_GEN_SQW_EN
        .sqw      (sqw[gi]),
`endif
        .tick     (tick[gi]),
        .busy     (busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: directed self-checking bench for tick_generator.
// NCH=5 so that cfg_ch=NCH is a representable, out-of-range index.
module tb_tick_generator;

  localparam int NCH = 5;
  localparam int CW  = 27;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           cfg_we = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_period = '0;
  logic           cfg_oneshot = 1'b0;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] busy;
`ifdef TICK_GEN_SQW_EN
  logic [NCH-1:0] sqw;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  tick_generator #(.NCH(NCH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_oneshot(cfg_oneshot),
    .tick       (tick),
`ifdef TICK_GEN_SQW_EN
    .sqw        (sqw),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           rst;
    logic           en;
    logic           we;
    logic [CHW-1:0] ch;
    logic [CW-1:0]  period;
    logic           oneshot;
    logic [NCH-1:0] exp_tick;
    logic [NCH-1:0] exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic r, e, w, input logic [CHW-1:0] c,
                      input logic [CW-1:0] p, input logic os,
                      input logic [NCH-1:0] et, eb);
    vec_t v;
    v.rst = r; v.en = e; v.we = w; v.ch = c; v.period = p; v.oneshot = os;
    v.exp_tick = et; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive inputs, take one edge, sample 1 time unit later.
  task automatic step(input logic r, e, w, input logic [CHW-1:0] c,
                      input logic [CW-1:0] p, input logic os);
    rst = r; en = e; cfg_we = w; cfg_ch = c; cfg_period = p; cfg_oneshot = os;
    @(posedge clk);
    #1;
  endtask

  // Count enabled edges until tick[c] is observed; n=-1 if the bound expires.
  task automatic wait_tick(input int c, input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
      if (tick[c]) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int cnt_ticks;

    // ---------------- idle after reset ----------------
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    cnt_ticks = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
      if (tick != '0 || busy != '0) cnt_ticks++;
    end
    chk("idle_100_cycles", 32'(cnt_ticks), 32'h0);
    $display("idle: 100 enabled cycles without writes, activity=%0d", cnt_ticks);

    // ---------------- table-driven vectors ----------------
    //   rst en we ch period os   exp_tick  exp_busy
    addv(1, 0, 0, 0, 0, 0, 5'b00000, 5'b00000); // 0  reset
    addv(0, 1, 1, 0, 5, 0, 5'b00000, 5'b00001); // 1  ch0 P=5 periodic
    addv(0, 1, 1, 1, 1, 0, 5'b00000, 5'b00011); // 2  ch1 P=1
    addv(0, 1, 1, 2, 3, 1, 5'b00010, 5'b00111); // 3  ch2 P=3 one-shot
    addv(0, 1, 0, 0, 0, 0, 5'b00010, 5'b00111); // 4
    addv(0, 1, 0, 0, 0, 0, 5'b00010, 5'b00111); // 5
    addv(0, 1, 0, 0, 0, 0, 5'b00111, 5'b00011); // 6  ch0 tick, ch2 fires and expires
    addv(0, 1, 0, 0, 0, 0, 5'b00010, 5'b00011); // 7
    addv(0, 1, 0, 0, 0, 0, 5'b00010, 5'b00011); // 8
    addv(0, 1, 0, 0, 0, 0, 5'b00010, 5'b00011); // 9
    addv(0, 1, 0, 0, 0, 0, 5'b00010, 5'b00011); // 10
    addv(0, 1, 0, 0, 0, 0, 5'b00011, 5'b00011); // 11 ch0 second tick, 5 later
    addv(0, 1, 0, 0, 0, 0, 5'b00010, 5'b00011); // 12
    addv(0, 0, 0, 0, 0, 0, 5'b00000, 5'b00011); // 13 en=0: no ticks
    addv(0, 1, 0, 0, 0, 0, 5'b00010, 5'b00011); // 14
    addv(0, 1, 0, 0, 0, 0, 5'b00010, 5'b00011); // 15
    addv(0, 1, 0, 0, 0, 0, 5'b00010, 5'b00011); // 16
    addv(0, 1, 0, 0, 0, 0, 5'b00011, 5'b00011); // 17 ch0 tick delayed by 1
    addv(0, 1, 1, 5, 7, 0, 5'b00010, 5'b00011); // 18 write to ch=NCH ignored
    addv(0, 1, 1, 1, 0, 0, 5'b00000, 5'b00001); // 19 ch1 P=0 disables
    addv(0, 1, 0, 0, 0, 0, 5'b00000, 5'b00001); // 20
    addv(0, 1, 0, 0, 0, 0, 5'b00000, 5'b00001); // 21
    addv(0, 1, 0, 0, 0, 0, 5'b00001, 5'b00001); // 22

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].we, vecs[i].ch, vecs[i].period, vecs[i].oneshot);
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].exp_tick));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      $display("vec %0d: tick=%b busy=%b", i, tick, busy);
    end

    // ---------------- one-shot quiet + re-arm ----------------
    step(1'b0, 1'b1, 1'b1, 3'd2, 27'd3, 1'b1);
    chk("os_arm_busy", 32'(busy[2]), 32'h1);
    wait_tick(2, 10, n);
    chk("os_first_tick_dist", 32'(n), 32'd3);
    chk("os_busy_falls_with_tick", 32'(busy[2]), 32'h0);
    cnt_ticks = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
      if (tick[2] || busy[2]) cnt_ticks++;
    end
    chk("os_quiet_50", 32'(cnt_ticks), 32'h0);
    step(1'b0, 1'b1, 1'b1, 3'd2, 27'd3, 1'b1);
    chk("os_rearm_busy", 32'(busy[2]), 32'h1);
    wait_tick(2, 10, n);
    chk("os_rearm_tick_dist", 32'(n), 32'd3);
    $display("oneshot: re-armed tick after %0d edges", n);

    // ---------------- pause en for 4 cycles, P=10 ----------------
    step(1'b0, 1'b1, 1'b1, 3'd0, 27'd10, 1'b0);
    wait_tick(0, 20, n);
    chk("p10_first_tick", 32'(n), 32'd10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    cnt_ticks = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      if (tick != '0) cnt_ticks++;
    end
    chk("pause_no_tick", 32'(cnt_ticks), 32'h0);
    wait_tick(0, 20, n);
    chk("pause_total_14", 32'(n + 7), 32'd14);
    $display("pause: next tick %0d edges after previous", n + 7);

    // ---------------- rewrite on terminal count ----------------
    step(1'b0, 1'b1, 1'b1, 3'd0, 27'd4, 1'b0);
    wait_tick(0, 10, n);
    chk("p4_first_tick", 32'(n), 32'd4);
    cnt_ticks = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
      if (tick[0]) cnt_ticks++;
    end
    chk("p4_mid_no_tick", 32'(cnt_ticks), 32'h0);
    step(1'b0, 1'b1, 1'b1, 3'd0, 27'd6, 1'b0);  // lands on terminal-count edge
    chk("tc_write_suppresses_tick", 32'(tick[0]), 32'h0);
    wait_tick(0, 12, n);
    chk("tc_write_next_tick_6", 32'(n), 32'd6);
    $display("tc rewrite: next tick after %0d edges", n);

    // ---------------- reset mid-count ----------------
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    chk("midrst_tick", 32'(tick), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    cnt_ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
      if (tick != '0 || busy != '0) cnt_ticks++;
    end
    chk("midrst_stays_idle", 32'(cnt_ticks), 32'h0);
    $display("mid-count reset: activity after reset=%0d", cnt_ticks);

`ifdef TICK_GEN_SQW_EN
    // ---------------- square wave, ch3 P=2 ----------------
    begin
      logic [7:0] exp_sqw;
      exp_sqw = 8'b01100110;  // bit i = sqw[3] after enabled edge i+1
      step(1'b0, 1'b1, 1'b1, 3'd3, 27'd2, 1'b0);
      chk("sqw_cleared_on_write", 32'(sqw[3]), 32'h0);
      for (int i = 0; i < 8; i++) begin
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        chk($sformatf("sqw_edge%0d", i + 1), 32'(sqw[3]), 32'(exp_sqw[i]));
      end
      $display("sqw: ch3 P=2 pattern checked over 8 edges");
    end
`endif

    // ---------------- wide period (above 16 bits) ----------------
    step(1'b0, 1'b1, 1'b1, 3'd3, 27'd70001, 1'b0);
    wait_tick(3, 70010, n);
    chk("wide_period_70001", 32'(n), 32'd70001);
    $display("wide: ch3 first tick after %0d edges", n);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tick_generator.md
# tick_generator

Multi-channel, run-time programmable tick generator: the parametrised successor to the fixed one-second/frame enable counters and clock dividers. Each of NCH independent channels emits a one-cycle `tick` strobe every P enabled cycles, in periodic or one-shot mode, with P loaded over a simple write port. It sits beside the top-level clock logic and feeds game-timer, frame-update and display-refresh enables. All outputs are data-path enables, never clocks.

## Interface
- `NCH`, default 4: number of channels, 1..16.
- `CW`, default 27: counter/period width in bits.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  global run; low freezes all counters.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_ch`  in  max(1,$clog2(NCH))  target channel of write.
- `cfg_period`  in  CW  period P in cycles; 0 = disable channel.
- `cfg_oneshot`  in  1  1 = one-shot mode, 0 = periodic mode.
- `tick`  out  NCH  per-channel one-cycle strobe, registered.
- `busy`  out  NCH  channel armed (P≠0 and not expired).
- `sqw`  out  NCH  divided square wave; present only with `TICK_GEN_SQW_EN`.

## Operation
- Per-channel state: `period[CW]`, `cnt[CW]`, `oneshot`, `busy`.
- Reset: `period=0`, `cnt=0`, `oneshot=0`, `busy=0`, `tick=0`, `sqw=0`, so every channel is disabled.
- Config write (`cfg_we=1`, `cfg_ch<NCH`): channel `period←cfg_period`, `oneshot←cfg_oneshot`, `cnt←0`, `busy←(cfg_period≠0)`, `tick←0` on that edge. A write with `cfg_ch≥NCH` is ignored.
- Counting happens on an edge where `en=1` and `busy=1` and there is no write to that channel.
  - If `cnt==period-1`: `cnt←0` and `tick←1`. In one-shot mode, also `busy←0`.
  - Otherwise: `cnt←cnt+1` and `tick←0`.
- `en=0`: `cnt` and `busy` hold and `tick←0`. Ticks are never stretched or queued.
- Idle channel (`busy=0`): `cnt` holds at 0 and `tick=0`.
- Arithmetic: compare against `period-1` at CW bits. P=0 never reaches the compare because `busy=0`.
- Precedence on one channel in one edge: `rst` > config write > terminal count. A write coinciding with terminal count restarts the channel and suppresses that tick.
- Channels are fully independent. Writes to channel i do not disturb channel j.

## Timing
- Write at edge W with P≥1 and `en` held high: first `tick` is high in the cycle after edge W+P. After that, one tick every P cycles.
- P=1 periodic: `tick` is high every cycle while `en=1`.
- Pausing `en` for k cycles delays every subsequent tick by exactly k cycles.
- `busy` falls on the same edge that raises the one-shot `tick`.
- Latency from config write to `busy` valid: 1 edge.

## Configuration
- `TICK_GEN_SQW_EN` defined:
  - Adds the `sqw` port.
  - `sqw[i]` toggles on every edge where `tick[i]` is set, giving period 2P and a 50% duty cycle.
  - `sqw[i]` is cleared on reset and on a config write to channel i.
  - It holds when `en=0` or the channel is idle.
- `TICK_GEN_SQW_EN` undefined: no `sqw` port and no toggle flops.

## Structure
- Package `tick_gen_pkg`:
  - constants `MAX_NCH=16` and `DEF_CW=27`;
  - localparam function for the channel-index width;
  - typedef `tick_mode_t` (`MODE_PERIODIC`, `MODE_ONESHOT`).
- Sub-module `tick_channel` (parameter CW) holds one channel's registers and next-state logic.
- The top decodes `cfg_ch` and instantiates NCH copies with a generate loop.

## Test plan
- Reset, then `en=1` for 100 cycles with no writes → `tick=0`, `busy=0`, `cnt=0` on all channels.
- Write ch0 P=5 periodic, `en=1` → ticks 5 cycles apart, the first 5 edges after the write, and each exactly 1 cycle wide. Write ch1 P=1 → `tick[1]` is continuously high.
- Write ch2 P=3 one-shot → exactly one tick, `busy[2]` falls with it, then no further ticks over 50 cycles. Rewrite ch2 → it re-arms.
- ch0 P=10: drop `en` for 4 cycles mid-count → the next tick arrives 14 cycles after the previous one, and `tick=0` throughout the pause.
- ch0 P=4: rewrite ch0 with P=6 on the terminal-count edge → no tick on that edge, and the next tick comes 6 edges later. A write with `cfg_ch=NCH` changes nothing. Asserting `rst` mid-count clears everything on the next edge.
- With `TICK_GEN_SQW_EN`, ch3 P=2 → `sqw[3]` has a period of 4 cycles (2 high, 2 low). Width check: CW=27, P=20_000_000 → first tick at exactly cycle 20_000_000.
